// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit-side port arbiter.
package gmii_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        IFG
    } tx_state_t;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam int unsigned PREAMBLE_LEN  = 8;

    // Width of the shared preamble/IFG down-counter.
    function automatic int unsigned cnt_width(input int unsigned ifg_bytes);
        int unsigned m;
        m = (ifg_bytes > PREAMBLE_LEN) ? ifg_bytes : PREAMBLE_LEN;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr wins,
// wrapping modulo NPORTS.
module rr_arbiter #(
    parameter int unsigned  NPORTS = 4,
    localparam int unsigned PW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     rr_ptr,
    output logic [NPORTS-1:0] gnt_onehot,
    output logic [PW-1:0]     gnt_index,
    output logic              gnt_valid
);

    // Scan upward from the pointer; the first asserted request takes the grant.
    always_comb begin
        int unsigned idx;
        gnt_onehot = '0;
        gnt_index  = '0;
        gnt_valid  = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            idx = (32'(rr_ptr) + i) % NPORTS;
            if (!gnt_valid && req[idx]) begin
                gnt_valid       = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_index       = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/gmii_tx_port_arbiter.sv
// N-port GMII transmit merger: round-robin selects one whole frame at a time,
// optionally prepends preamble/SFD and enforces the inter-frame gap.
module gmii_tx_port_arbiter
    import gmii_pkg::*;
#(
    parameter int unsigned  NPORTS      = 4,
    parameter int unsigned  PREAMBLE_EN = 1,
    parameter int unsigned  IFG_BYTES   = 11,
    localparam int unsigned PW          = $clog2(NPORTS)
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic [NPORTS-1:0]   port_enable,
    input  logic [NPORTS*8-1:0] in_data,
    input  logic [NPORTS-1:0]   in_valid,
    input  logic [NPORTS-1:0]   in_last,
    output logic [NPORTS-1:0]   in_ready,
    output logic [7:0]          gmii_txd,
    output logic                gmii_tx_en,
    output logic                gmii_tx_er,
    output logic [PW-1:0]       grant_port,
    output logic                busy,
    output logic                underrun
);

    localparam int unsigned CW = cnt_width(IFG_BYTES);

    tx_state_t       state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            tail, tail_nx;
    logic            und_seen, und_seen_nx;
    logic [PW-1:0]   rr_ptr, rr_ptr_nx;
    logic [PW-1:0]   grant_nx;

    logic [7:0]      txd_nx;
    logic            tx_en_nx, tx_er_nx, underrun_nx;

    logic [NPORTS-1:0] cand, win_oh;
    logic [PW-1:0]     win_idx;
    logic              win_valid;

    logic [7:0]      g_data, w_data;
    logic            g_valid, g_last, w_last;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (p == PW'(NPORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cand = in_valid & port_enable;
    assign busy = (state != IDLE);

    rr_arbiter #(
        .NPORTS (NPORTS)
    ) u_rr_arbiter (
        .req        (cand),
        .rr_ptr     (rr_ptr),
        .gnt_onehot (win_oh),
        .gnt_index  (win_idx),
        .gnt_valid  (win_valid)
    );

    // Byte/valid/last of the granted port and of the arbitration winner.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        w_data  = '0;
        w_last  = 1'b0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (PW'(i) == grant_port) begin
                g_data  = in_data[8*i +: 8];
                g_valid = in_valid[i];
                g_last  = in_last[i];
            end
            if (win_oh[i]) begin
                w_data = in_data[8*i +: 8];
                w_last = in_last[i];
            end
        end
    end

    // State register plus registered GMII outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tail       <= 1'b0;
            und_seen   <= 1'b0;
            rr_ptr     <= '0;
            grant_port <= '0;
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            tail       <= tail_nx;
            und_seen   <= und_seen_nx;
            rr_ptr     <= rr_ptr_nx;
            grant_port <= grant_nx;
            gmii_txd   <= txd_nx;
            gmii_tx_en <= tx_en_nx;
            gmii_tx_er <= tx_er_nx;
            underrun   <= underrun_nx;
        end
    end

    // Next-state logic. The first preamble byte is launched on the IDLE exit
    // edge, so PREAMBLE only counts the remaining seven. After the last byte is
    // accepted, DATA holds one extra 'tail' cycle while that byte is on the wire.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        tail_nx     = tail;
        und_seen_nx = und_seen;
        rr_ptr_nx   = rr_ptr;
        grant_nx    = grant_port;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_nx    = win_idx;
                    und_seen_nx = 1'b0;
                    if (PREAMBLE_EN != 0) begin
                        state_nx = PREAMBLE;
                        cnt_nx   = CW'(PREAMBLE_LEN - 2);
                        tail_nx  = 1'b0;
                    end else begin
                        state_nx = DATA;
                        tail_nx  = w_last;
                        if (w_last) begin
                            rr_ptr_nx = next_port(win_idx);
                        end
                    end
                end
            end
            PREAMBLE: begin
                if (cnt == '0) begin
                    state_nx = DATA;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DATA: begin
                if (tail) begin
                    tail_nx = 1'b0;
                    if (IFG_BYTES == 0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = IFG;
                        cnt_nx   = CW'(IFG_BYTES - 1);
                    end
                end else if (g_valid) begin
                    if (g_last) begin
                        tail_nx   = 1'b1;
                        rr_ptr_nx = next_port(grant_port);
                    end
                end else begin
                    und_seen_nx = 1'b1;
                end
            end
            IFG: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next values of the GMII registers and the ready strobes.
    always_comb begin
        txd_nx      = '0;
        tx_en_nx    = 1'b0;
        tx_er_nx    = 1'b0;
        underrun_nx = 1'b0;
        in_ready    = '0;
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    tx_en_nx = 1'b1;
                    if (PREAMBLE_EN != 0) begin
                        txd_nx = GMII_PREAMBLE;
                    end else begin
                        txd_nx   = w_data;
                        in_ready = win_oh;
                    end
                end
            end
            PREAMBLE: begin
                tx_en_nx = 1'b1;
                txd_nx   = (cnt == '0) ? GMII_SFD : GMII_PREAMBLE;
            end
            DATA: begin
                if (!tail) begin
                    tx_en_nx = 1'b1;
                    for (int unsigned i = 0; i < NPORTS; i++) begin
                        if (PW'(i) == grant_port) begin
                            in_ready[i] = 1'b1;
                        end
                    end
                    if (g_valid) begin
                        txd_nx = g_data;
                    end else begin
                        tx_er_nx    = 1'b1;
                        underrun_nx = !und_seen;
                    end
                end
            end
            IFG: begin
                tx_en_nx = 1'b0;
            end
            default: tx_en_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_gmii_tx_port_arbiter.sv
// Directed bench for gmii_tx_port_arbiter: a 4-port instance with preamble and
// 11-byte IFG, plus a 2-port instance without preamble and a 3-byte IFG.
module tb_gmii_tx_port_arbiter;

    logic        clk;
    logic        reset;

    logic [3:0]  a_en, a_valid, a_last, a_ready;
    logic [31:0] a_data;
    logic [7:0]  txd;
    logic        tx_en, tx_er, busy, underrun;
    logic [1:0]  grant;

    logic [1:0]  b_valid, b_last, b_ready;
    logic [15:0] b_data;
    logic [7:0]  b_txd;
    logic        b_tx_en, b_tx_er, b_busy, b_underrun;
    logic        b_grant;

    gmii_tx_port_arbiter #(
        .NPORTS      (4),
        .PREAMBLE_EN (1),
        .IFG_BYTES   (11)
    ) dut_a (
        .sys_clk     (clk),
        .reset       (reset),
        .port_enable (a_en),
        .in_data     (a_data),
        .in_valid    (a_valid),
        .in_last     (a_last),
        .in_ready    (a_ready),
        .gmii_txd    (txd),
        .gmii_tx_en  (tx_en),
        .gmii_tx_er  (tx_er),
        .grant_port  (grant),
        .busy        (busy),
        .underrun    (underrun)
    );

    gmii_tx_port_arbiter #(
        .NPORTS      (2),
        .PREAMBLE_EN (0),
        .IFG_BYTES   (3)
    ) dut_b (
        .sys_clk     (clk),
        .reset       (reset),
        .port_enable (2'b11),
        .in_data     (b_data),
        .in_valid    (b_valid),
        .in_last     (b_last),
        .in_ready    (b_ready),
        .gmii_txd    (b_txd),
        .gmii_tx_en  (b_tx_en),
        .gmii_tx_er  (b_tx_er),
        .grant_port  (b_grant),
        .busy        (b_busy),
        .underrun    (b_underrun)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Source model state for dut_a.
    int flen[4], nfr[4], pos[4], st_at[4], st_len[4], st_cnt[4];
    // Source model for dut_b: port 0 streams one-byte frames.
    logic       b_on;
    logic [7:0] b_byte;

    // Monitors.
    logic [8:0] wq[$];
    int         rise_q[$], fall_q[$], gnt_q[$];
    int         und_cnt, er_cnt, b_er_cnt;
    logic       prev_en;
    logic [3:0] ready_seen;
    logic       b_rec;
    int         b_d;
    logic       b_hist[20];
    logic [7:0] b_txd_h[20];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit pend();
        return (nfr[0] > 0) || (nfr[1] > 0) || (nfr[2] > 0) || (nfr[3] > 0);
    endfunction

    task automatic drive_src();
        for (int p = 0; p < 4; p++) begin
            if (nfr[p] > 0 && pos[p] == st_at[p] && st_cnt[p] < st_len[p]) begin
                st_cnt[p]++;
                a_valid[p] = 1'b0;
            end else begin
                a_valid[p] = (nfr[p] > 0);
            end
            a_data[8*p +: 8] = 8'(pos[p]);
            a_last[p]        = (pos[p] == flen[p] - 1);
        end
        b_valid = {1'b0, b_on};
        b_data  = {8'h00, b_byte};
        b_last  = 2'b11;
    endtask

    task automatic clr();
        wq.delete();
        rise_q.delete();
        fall_q.delete();
        gnt_q.delete();
        und_cnt    = 0;
        er_cnt     = 0;
        ready_seen = '0;
    endtask

    task automatic cycle();
        logic [3:0] acc;
        logic [1:0] bacc;
        @(negedge clk);
        acc        = a_valid & a_ready;
        bacc       = b_valid & b_ready;
        ready_seen = ready_seen | a_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_en) wq.push_back({tx_er, txd});
        if (tx_en && !prev_en) begin
            rise_q.push_back(cyc);
            gnt_q.push_back(int'(grant));
        end
        if (!tx_en && prev_en) fall_q.push_back(cyc);
        if (underrun) und_cnt++;
        if (tx_er) er_cnt++;
        prev_en = tx_en;
        if (b_rec && (cyc - b_d) < 20) begin
            b_hist[cyc - b_d]  = b_tx_en;
            b_txd_h[cyc - b_d] = b_txd;
        end
        if (b_tx_er) b_er_cnt++;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) begin
                if (pos[p] == flen[p] - 1) begin
                    pos[p] = 0;
                    nfr[p]--;
                end else begin
                    pos[p]++;
                end
            end
        end
        if (bacc[0]) b_byte++;
        drive_src();
    endtask

    task automatic run_idle(input int maxc, input string tag);
        int n = 0;
        while ((pend() || busy) && n < maxc) begin
            cycle();
            n++;
        end
        chk(tag, (n < maxc), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    initial begin
        int d1, n, bad;
        logic [19:0] bv;
        logic [8:0]  e;
        reset = 1'b1;
        a_en  = 4'hF;
        b_on  = 1'b0;
        b_byte = '0;
        b_rec = 1'b0;
        b_d   = 0;
        b_er_cnt = 0;
        prev_en = 1'b0;
        for (int p = 0; p < 4; p++) begin
            flen[p] = 1; nfr[p] = 0; pos[p] = 0;
            st_at[p] = -1; st_len[p] = 0; st_cnt[p] = 0;
        end
        for (int k = 0; k < 20; k++) begin
            b_hist[k] = 1'b0;
            b_txd_h[k] = '0;
        end
        drive_src();
        clr();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        #1;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_txd", txd, 0);
        chk("rst_tx_er", tx_er, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_in_ready", a_ready, 0);
        chk("rst_b_in_ready", b_ready, 0);

        // 1: single 60-byte frame from port 2 with preamble.
        clr();
        flen[2] = 60; nfr[2] = 1;
        drive_src();
        d1 = cyc;
        run_idle(300, "t1_timeout");
        chk("t1_rises", rise_q.size(), 1);
        chk("t1_latency", rise_q[0] - d1, 1);
        chk("t1_grant", gnt_q[0], 2);
        chk("t1_en_len", fall_q[0] - rise_q[0], 68);
        chk("t1_bytes", wq.size(), 68);
        bad = 0;
        for (int i = 0; i < 68 && i < wq.size(); i++) begin
            e = (i < 7) ? 9'h055 : (i == 7) ? 9'h0D5 : 9'(i - 8);
            if (wq[i] !== e) bad++;
        end
        chk("t1_byte_errs", bad, 0);
        chk("t1_ready_other", ready_seen & 4'b1011, 0);
        chk("t1_tx_er", er_cnt, 0);

        // 2: ports 0,1,3 two frames each, rotation and 12-cycle gap.
        do_reset();
        clr();
        flen[0] = 5; flen[1] = 6; flen[3] = 7;
        nfr[0] = 2;  nfr[1] = 2;  nfr[3] = 2;
        drive_src();
        run_idle(600, "t2_timeout");
        chk("t2_rises", rise_q.size(), 6);
        for (int i = 0; i < 6 && i < rise_q.size() && i < fall_q.size(); i++) begin
            chk($sformatf("t2_grant%0d", i), gnt_q[i], (i % 3 == 2) ? 3 : i % 3);
            chk($sformatf("t2_len%0d", i), fall_q[i] - rise_q[i], 13 + (i % 3));
            if (i > 0) chk($sformatf("t2_gap%0d", i), rise_q[i] - fall_q[i-1], 12);
        end

        // 3: port 1 stalls for three cycles mid-frame.
        clr();
        flen[1] = 20; nfr[1] = 1; st_at[1] = 10; st_len[1] = 3; st_cnt[1] = 0;
        drive_src();
        run_idle(200, "t3_timeout");
        st_at[1] = -1;
        chk("t3_bytes", wq.size(), 31);
        chk("t3_er_cycles", er_cnt, 3);
        chk("t3_underrun_pulses", und_cnt, 1);
        chk("t3_before", wq[17], 9'h009);
        chk("t3_er0", wq[18], 9'h100);
        chk("t3_er2", wq[20], 9'h100);
        chk("t3_resume", wq[21], 9'h00A);
        chk("t3_lastbyte", wq[30], 9'h013);

        // 4: port 2 masked; enabled mid-frame of port 0.
        clr();
        a_en = 4'b1011;
        flen[2] = 6; nfr[2] = 1;
        drive_src();
        repeat (30) cycle();
        chk("t4_masked_rises", rise_q.size(), 0);
        chk("t4_masked_busy", busy, 0);
        flen[0] = 30; nfr[0] = 1;
        drive_src();
        repeat (15) cycle();
        a_en = 4'hF;
        run_idle(400, "t4_timeout");
        chk("t4_rises", rise_q.size(), 2);
        chk("t4_grant0", gnt_q[0], 0);
        chk("t4_grant1", gnt_q[1], 2);

        // 5: reset while payload byte 20 is on the wire.
        clr();
        flen[3] = 40; nfr[3] = 1;
        drive_src();
        n = 0;
        while (wq.size() < 29 && n < 200) begin
            cycle();
            n++;
        end
        chk("t5_reach_timeout", (n < 200), 1);
        chk("t5_byte20", wq[28], 9'h014);
        reset = 1'b1;
        cycle();
        #1;
        chk("t5_tx_en", tx_en, 0);
        chk("t5_in_ready", a_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_er", er_cnt, 0);
        nfr[3] = 0; pos[3] = 0;
        reset = 1'b0;
        drive_src();
        cycle();
        clr();
        flen[1] = 4; flen[3] = 4; nfr[1] = 1; nfr[3] = 1;
        drive_src();
        run_idle(300, "t5_after_timeout");
        chk("t5_rises", rise_q.size(), 2);
        chk("t5_grant0", gnt_q[0], 1);
        chk("t5_grant1", gnt_q[1], 3);
        chk("t5_pre0", wq[0], 9'h055);
        chk("t5_sfd", wq[7], 9'h0D5);
        chk("t5_pay0", wq[8], 9'h000);

        // 6: no preamble, 3-byte IFG, stream of one-byte frames on dut_b.
        b_on = 1'b1;
        drive_src();
        b_d = cyc;
        b_rec = 1'b1;
        repeat (20) cycle();
        b_rec = 1'b0;
        b_on = 1'b0;
        drive_src();
        repeat (6) cycle();
        for (int k = 0; k < 20; k++) bv[k] = b_hist[k];
        chk("t6_en_pattern", bv, 20'h10842);
        chk("t6_byte0", b_txd_h[1], 8'h00);
        chk("t6_byte1", b_txd_h[6], 8'h01);
        chk("t6_byte2", b_txd_h[11], 8'h02);
        chk("t6_byte3", b_txd_h[16], 8'h03);
        chk("t6_tx_er", b_er_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
